conv_encoder: RTL and testbench

- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder front end.
- Accepts a serial bit stream in frames over a valid/ready handshake.
- Emits one 2-bit code symbol per input bit.
- Appends K-1 = 2 zero tail bits per frame, so the decoder trellis terminates in state 0.
- Output symbol bit ordering matches the decoder's data_recv / path_id convention.

---
 rtl/conv_encoder.sv | 74 +++++++
 tb/tb_conv_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 convolutional encoder with framed valid/ready I/O and zero tail
module conv_encoder #(
    parameter logic [2:0] G0    = 3'b111,
    parameter logic [2:0] G1    = 3'b101,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [1:0]       data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic [CNT_W-1:0] sym_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;

    logic [1:0] state;
    logic       s1, s0, tail_cnt;
    logic       slot_free, acc, emit, u;
    logic [2:0] taps;

    // handshake qualification and encoder taps; tail bits feed zeros
    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = slot_free && (state != TAIL);
        acc       = in_valid && in_ready;
        emit      = slot_free && (state == TAIL);
        u         = (state == TAIL) ? 1'b0 : in_bit;
        taps      = {u, s1, s0};
    end

    // symbol register, shift register and frame sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s0        <= 1'b0;
            tail_cnt  <= 1'b0;
            data_out  <= 2'b00;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            sym_cnt   <= '0;
        end else begin
            if (acc || emit) begin
                data_out  <= {^(taps & G1), ^(taps & G0)};
                out_valid <= 1'b1;
                s1        <= u;
                s0        <= s1;
                out_first <= acc && (state == IDLE);
                out_last  <= emit && tail_cnt;
                sym_cnt   <= (acc && (state == IDLE)) ? CNT_W'(1) : sym_cnt + 1'b1;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
            if (acc && in_last) begin
                state    <= TAIL;
                tail_cnt <= 1'b0;
            end else if (acc) begin
                state <= DATA;
            end else if (emit) begin
                tail_cnt <= !tail_cnt;
                if (tail_cnt) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: randomized frame-level check of conv_encoder against a polynomial reference model
module tb_conv_encoder;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic             in_ready;
    logic [1:0]       data_out;
    logic             out_valid, out_first, out_last;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] sym_cnt;

    conv_encoder #(.G0(G0), .G1(G1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       d;
        logic             f;
        logic             l;
        logic [CNT_W-1:0] c;
    } sym_t;

    sym_t exp_q[$];
    int   n_cmp = 0, n_err = 0;
    int   tail_pend = 0;
    int   rdy_mode = 0;
    int   ph = 0;
    logic held_v = 1'b0;
    sym_t held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // downstream ready pattern: 0 always, 1 periodic 1,0,0, 2 random
    always @(negedge clk) begin
        ph++;
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (ph % 3 == 0) : 1'($urandom_range(1));
    end

    // monitor: scoreboard pop on transfer, hold stability, in_ready model
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (held_v) begin
                chk("hold_d", data_out, held.d);
                chk("hold_f", out_first, held.f);
                chk("hold_l", out_last, held.l);
                chk("hold_c", sym_cnt, held.c);
            end
            held_v = out_valid && !out_ready;
            held   = {data_out, out_first, out_last, sym_cnt};
            chk("in_ready", in_ready, (!out_valid || out_ready) && tail_pend == 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious", 1, 0);
                else begin
                    sym_t e;
                    e = exp_q.pop_front();
                    chk("data", data_out, e.d);
                    chk("first", out_first, e.f);
                    chk("last", out_last, e.l);
                    chk("cnt", sym_cnt, e.c);
                end
            end
            if (tail_pend > 0 && (!out_valid || out_ready)) tail_pend--;
            else if (in_valid && in_ready && in_last) tail_pend = 2;
        end
    end

    // reference: each symbol is the GF(2) dot product of the generator with the last 3 bits
    task automatic push_frame(input logic [63:0] bits, input int n);
        for (int j = 0; j < n + 2; j++) begin
            sym_t e;
            logic g0, g1, b;
            g0 = 0;
            g1 = 0;
            for (int k = 0; k < 3; k++) begin
                b = (j - k >= 0 && j - k < n) ? bits[j-k] : 1'b0;
                g0 ^= b & G0[2-k];
                g1 ^= b & G1[2-k];
            end
            e.d = {g1, g0};
            e.f = (j == 0);
            e.l = (j == n + 1);
            e.c = CNT_W'(j + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n, input int vprob, input int abort_at);
        push_frame(bits, n);
        for (int i = 0; i < n; i++) begin
            int t;
            if (i == abort_at) return;
            t = 0;
            forever begin
                @(negedge clk);
                in_valid = (vprob >= 100) ? 1'b1 : ($urandom_range(99) < vprob);
                in_bit   = bits[i];
                in_last  = (i == n - 1);
                #1;
                if (in_valid && in_ready) break;
                if (++t > 1000) begin
                    chk("accept_timeout", 0, 1);
                    return;
                end
            end
        end
    endtask

    task automatic idle_drain();
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        tail_pend = 0;
        held_v = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_cnt", sym_cnt, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ready", in_ready, 1);
    endtask

    initial begin
        do_reset();
        rdy_mode = 0;
        send_frame(64'b1101, 4, 100, -1);
        idle_drain();
        rdy_mode = 1;
        send_frame(64'b1101, 4, 100, -1);
        idle_drain();
        rdy_mode = 0;
        send_frame(64'b1, 1, 100, -1);
        idle_drain();
        send_frame(64'b1, 1, 100, -1);
        send_frame(64'b10, 2, 100, -1);
        idle_drain();
        send_frame(64'b0, 8, 100, -1);
        idle_drain();
        rdy_mode = 1;
        send_frame(64'b1011_0111, 8, 100, 5);
        do_reset();
        rdy_mode = 0;
        send_frame(64'b11, 2, 100, -1);
        idle_drain();
        for (int r = 0; r < 60; r++) begin
            logic [63:0] bits;
            rdy_mode = $urandom_range(2);
            bits = {$urandom, $urandom};
            send_frame(bits, $urandom_range(20, 1), (r % 2) ? 100 : 70, -1);
            if (r % 7 == 6) idle_drain();
        end
        idle_drain();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
